// File: rtl/cpu_run_controller.sv
// -----------------------------------------------------------------------------
// cpu_run_controller
//   Boot/run sequencer for the pipelined RISC-V core. It streams a program
//   byte-wise into the 8-bit program memory over a valid/ready port and keeps
//   the core (PC + pipeline) in reset while loading. Afterwards it runs, halts
//   or single-steps the core on host commands, and counts enabled core cycles.
//
// Parameters
//   ADD_WIDTH   program memory byte-address width (DEPTH = 2**ADD_WIDTH bytes)
//   CNT_WIDTH   width of cycle_count
//
// Ports
//   clk          in   rising-edge system clock
//   rst          in   asynchronous reset, active-low
//   load_start   in   pulse: start loading load_len bytes from address 0
//   load_len     in   byte count (0 ignored, larger than DEPTH clamped to DEPTH)
//   load_data    in   program byte
//   load_valid   in   load_data valid
//   load_ready   out  a byte is accepted this cycle if load_valid is high
//   run_cmd      in   free-run the core
//   halt_cmd     in   freeze the core
//   step_cmd     in   advance the core by exactly one clock
//   mem_wen      out  program memory write enable
//   mem_wadd     out  program memory write address
//   mem_wdata    out  program memory write data
//   cpu_hold     out  1 = keep core in reset
//   cpu_en       out  core clock enable
//   state        out  IDLE=0 LOAD=1 READY=2 RUN=3 STEP=4 HALT=5
//   cycle_count  out  saturating count of cpu_en cycles since the last load
// -----------------------------------------------------------------------------
module cpu_run_controller #(
    parameter int ADD_WIDTH = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    input  logic [ADD_WIDTH:0]   load_len,
    input  logic [7:0]           load_data,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic                 run_cmd,
    input  logic                 halt_cmd,
    input  logic                 step_cmd,
    output logic                 mem_wen,
    output logic [ADD_WIDTH-1:0] mem_wadd,
    output logic [7:0]           mem_wdata,
    output logic                 cpu_hold,
    output logic                 cpu_en,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_READY = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_STEP  = 3'd4;
    localparam logic [2:0] ST_HALT  = 3'd5;

    localparam logic [ADD_WIDTH:0]   DEPTH_C   = {1'b1, {ADD_WIDTH{1'b0}}};
    localparam logic [ADD_WIDTH:0]   LEN_ONE_C = (ADD_WIDTH+1)'(1);
    localparam logic [ADD_WIDTH-1:0] ADDR_ONE_C = ADD_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE_C = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX_C = {CNT_WIDTH{1'b1}};

    logic [2:0]           state_r;
    logic [2:0]           next_state_s;
    logic                 load_entry_s;
    logic                 load_go_s;
    logic                 accept_s;
    logic [ADD_WIDTH:0]   len_clamped_s;
    logic [ADD_WIDTH-1:0] addr_r;
    logic [ADD_WIDTH:0]   remaining_r;
    logic                 load_ready_r;
    logic                 mem_wen_r;
    logic [ADD_WIDTH-1:0] mem_wadd_r;
    logic [7:0]           mem_wdata_r;
    logic                 cpu_hold_r;
    logic                 cpu_en_r;
    logic [CNT_WIDTH-1:0] cycle_count_r;

    // A zero-length load request counts as no request at all.
    assign load_go_s     = load_start && (load_len != {(ADD_WIDTH+1){1'b0}});
    assign len_clamped_s = (load_len > DEPTH_C) ? DEPTH_C : load_len;
    assign accept_s      = (state_r == ST_LOAD) && load_ready_r && load_valid;

    // Next-state decode; commands a state does not listen to never mask lower-priority ones.
    always_comb begin
        next_state_s = state_r;
        load_entry_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_READY, ST_HALT: begin
                if (load_go_s) begin
                    next_state_s = ST_LOAD;
                    load_entry_s = 1'b1;
                end else if (step_cmd) begin
                    next_state_s = ST_STEP;
                end else if (run_cmd) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_LOAD: begin
                // Leave on the edge that accepts the final byte.
                if (accept_s && (remaining_r == LEN_ONE_C)) begin
                    next_state_s = ST_READY;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (halt_cmd) begin
                    next_state_s = ST_HALT;
                end else if (load_go_s) begin
                    next_state_s = ST_LOAD;
                    load_entry_s = 1'b1;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_STEP: begin
                next_state_s = ST_HALT;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Core control outputs, registered from the next state so they align with state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_hold_r   <= 1'b1;
            cpu_en_r     <= 1'b0;
            load_ready_r <= 1'b0;
        end else begin
            cpu_hold_r   <= (next_state_s == ST_IDLE) || (next_state_s == ST_LOAD) ||
                            (next_state_s == ST_READY);
            cpu_en_r     <= (next_state_s == ST_RUN) || (next_state_s == ST_STEP);
            load_ready_r <= (next_state_s == ST_LOAD);
        end
    end

    // Load datapath: address/remaining counters and the one-cycle-delayed write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r      <= {ADD_WIDTH{1'b0}};
            remaining_r <= {(ADD_WIDTH+1){1'b0}};
            mem_wen_r   <= 1'b0;
            mem_wadd_r  <= {ADD_WIDTH{1'b0}};
            mem_wdata_r <= 8'h00;
        end else begin
            if (load_entry_s) begin
                addr_r      <= {ADD_WIDTH{1'b0}};
                remaining_r <= len_clamped_s;
            end else if (accept_s) begin
                // Natural overflow provides the wrap at DEPTH.
                addr_r      <= addr_r + ADDR_ONE_C;
                remaining_r <= remaining_r - LEN_ONE_C;
            end else begin
                addr_r      <= addr_r;
                remaining_r <= remaining_r;
            end
            mem_wen_r <= accept_s;
            if (accept_s) begin
                mem_wadd_r  <= addr_r;
                mem_wdata_r <= load_data;
            end else begin
                mem_wadd_r  <= mem_wadd_r;
                mem_wdata_r <= mem_wdata_r;
            end
        end
    end

    // Saturating enabled-cycle counter; a new load wins over the increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count_r <= {CNT_WIDTH{1'b0}};
        end else if (load_entry_s) begin
            cycle_count_r <= {CNT_WIDTH{1'b0}};
        end else if (cpu_en_r && (cycle_count_r != CNT_MAX_C)) begin
            cycle_count_r <= cycle_count_r + CNT_ONE_C;
        end else begin
            cycle_count_r <= cycle_count_r;
        end
    end

    assign state       = state_r;
    assign load_ready  = load_ready_r;
    assign mem_wen     = mem_wen_r;
    assign mem_wadd    = mem_wadd_r;
    assign mem_wdata   = mem_wdata_r;
    assign cpu_hold    = cpu_hold_r;
    assign cpu_en      = cpu_en_r;
    assign cycle_count = cycle_count_r;

endmodule
